// File: rtl/seg7_disp_arbiter.sv
// seg7_disp_arbiter
//   Two requesters share one 4-digit hex display. The first grant is
//   immediate. After a grant the value is held for HOLD_CYCLES before the
//   other requester may take the display. The current owner may refresh its
//   value at any time during the hold. Ties at an arbitration point are
//   broken round-robin.
//
//   Optional feature (macro SEG7_ARB_TIMEOUT_EN): blank the display after
//   TIMEOUT_CYCLES consecutive idle cycles with no eligible request.
//
// Ports
//   clk          clock, rising edge
//   clr          asynchronous active-high reset
//   req0/req1    display-update request from requester 0/1
//   data0/data1  16-bit value offered (nibble [3:0] = rightmost digit)
//   ack0/ack1    registered one-cycle acceptance pulse
//   disp_x       registered value for the 7-segment digit driver
//   disp_owner   requester whose value is shown
//   disp_valid   high once any value has been accepted
//   busy         high while holding a granted value
module seg7_disp_arbiter #(
  parameter int unsigned HOLD_CYCLES    = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] disp_x,
  output logic        disp_owner,
  output logic        disp_valid,
  output logic        busy
);

  localparam int unsigned HC = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
  localparam int unsigned HW = (HC > 1) ? $clog2(HC) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state;
  logic [HW-1:0] cnt;
  logic          last;      // last granted requester, drives round-robin

`ifdef SEG7_ARB_TIMEOUT_EN
  localparam int unsigned TC = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
  localparam int unsigned TW = (TC > 1) ? $clog2(TC) : 1;
  logic [TW-1:0] tcnt;
`endif

  // A requester is ineligible on the edge its own ack is visible, so a
  // req held through its ack does not win a second time.
  logic elig0, elig1, any_elig, rr_win, owner_elig;
  logic do_grant, win;

  assign elig0      = req0 & ~ack0;
  assign elig1      = req1 & ~ack1;
  assign any_elig   = elig0 | elig1;
  assign rr_win     = (elig0 & elig1) ? ~last : elig1;
  assign owner_elig = disp_owner ? elig1 : elig0;

  always_comb begin
    do_grant = 1'b0;
    win      = rr_win;
    case (state)
      IDLE: do_grant = any_elig;
      HOLD: begin
        // Hold expiry is an arbitration point; before it only the owner
        // may refresh, and that refresh does not rotate priority.
        if (cnt == '0) begin
          do_grant = any_elig;
        end else if (owner_elig) begin
          do_grant = 1'b1;
          win      = disp_owner;
        end
      end
      default: do_grant = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= 1'b1;
      disp_x     <= 16'h0000;
      disp_owner <= 1'b0;
      disp_valid <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
`ifdef SEG7_ARB_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (do_grant) begin
        disp_x     <= win ? data1 : data0;
        disp_owner <= win;
        last       <= win;
        disp_valid <= 1'b1;
        ack0       <= ~win;
        ack1       <= win;
        state      <= HOLD;
        busy       <= 1'b1;
        cnt        <= HW'(HC - 1);
`ifdef SEG7_ARB_TIMEOUT_EN
        tcnt       <= '0;
`endif
      end else if (state == HOLD) begin
        if (cnt == '0) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
`ifdef SEG7_ARB_TIMEOUT_EN
      else if (disp_valid) begin
        // Idle with a value shown and nobody asking: count towards blank.
        if (tcnt == TW'(TC - 1)) begin
          tcnt       <= '0;
          disp_x     <= 16'h0000;
          disp_valid <= 1'b0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_seg7_disp_arbiter.sv
module tb_seg7_disp_arbiter;
  localparam int HOLD = 4;
  localparam int TOUT = 8;

  logic        clk = 1'b0;
  logic        clr, req0, req1;
  logic [15:0] data0, data1;
  logic        ack0, ack1, disp_owner, disp_valid, busy;
  logic [15:0] disp_x;

  int checks = 0;
  int errors = 0;

  seg7_disp_arbiter #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .clr(clr), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1), .disp_x(disp_x), .disp_owner(disp_owner),
    .disp_valid(disp_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: time-since-last-grant view of the display rules.
  // Before any grant, or once HOLD edges have passed since the last grant,
  // the display is open to round-robin arbitration; otherwise only the
  // current owner can refresh it.
  logic [15:0] m_disp;
  logic        m_owner, m_valid, m_ack0, m_ack1, m_hasg;
  int          m_n, m_g;

  function automatic void m_reset();
    m_disp = 16'h0; m_owner = 1'b0; m_valid = 1'b0;
    m_ack0 = 1'b0; m_ack1 = 1'b0; m_hasg = 1'b0; m_n = 0; m_g = 0;
  endfunction

  function automatic void m_step(input logic r0, input logic r1,
                                 input logic [15:0] d0, input logic [15:0] d1);
    logic e0, e1, open, last, have;
    logic w;
    e0 = r0 && !m_ack0;
    e1 = r1 && !m_ack1;
    m_n++;
    open = !m_hasg || (m_n - m_g) >= HOLD;
    last = m_hasg ? m_owner : 1'b1;
    have = 1'b0; w = 1'b0;
    if (open) begin
      if (e0 && e1) begin have = 1'b1; w = !last; end
      else if (e0) begin have = 1'b1; w = 1'b0; end
      else if (e1) begin have = 1'b1; w = 1'b1; end
    end else if (m_owner ? e1 : e0) begin
      have = 1'b1; w = m_owner;
    end
    m_ack0 = have && !w;
    m_ack1 = have && w;
    if (have) begin
      m_disp = w ? d1 : d0; m_owner = w; m_valid = 1'b1;
      m_hasg = 1'b1; m_g = m_n;
    end
`ifdef SEG7_ARB_TIMEOUT_EN
    else if (m_valid && m_hasg && (m_n - m_g) == HOLD + TOUT) begin
      m_disp = 16'h0; m_valid = 1'b0;
    end
`endif
  endfunction

  always @(posedge clr) m_reset();

  // Cycle monitor: inputs change only on falling edges, so at posedge+1
  // they are exactly the values sampled by the DUT.
  always begin
    @(posedge clk);
    #1;
    if (clr) m_reset();
    else m_step(req0, req1, data0, data1);
    chk("mon_ack0", ack0, m_ack0);
    chk("mon_ack1", ack1, m_ack1);
    chk("mon_disp", disp_x, m_disp);
    chk("mon_owner", disp_owner, m_owner);
    chk("mon_valid", disp_valid, m_valid);
    chk("mon_busy", busy, m_hasg && (m_n - m_g) < HOLD);
    chk("mon_ack_excl", ack0 & ack1, 1'b0);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ack0"}, ack0, 1'b0);
    chk({tag, "_ack1"}, ack1, 1'b0);
    chk({tag, "_disp"}, disp_x, 16'h0);
    chk({tag, "_owner"}, disp_owner, 1'b0);
    chk({tag, "_valid"}, disp_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // Pulse clr between edges and check the outputs drop at once.
  task automatic clr_pulse(input string tag);
    @(posedge clk);
    #3 clr = 1'b1;
    #1 chk_reset_outs(tag);
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic wait_ack1(input string tag, input int exp_gap);
    int i;
    for (i = 1; i <= 12; i++) begin
      tick();
      if (ack1) break;
    end
    chk(tag, i, exp_gap);
  endtask

  logic pend0, pend1;

  initial begin
    clr = 1'b1; req0 = 0; req1 = 0; data0 = 0; data1 = 0;
    repeat (2) tick();
    chk_reset_outs("reset");
    clr = 1'b0;
    tick();

    // First grant, one-cycle latency
    req0 = 1; data0 = 16'h1234;
    tick();
    chk("g1_ack0", ack0, 1'b1);
    chk("g1_disp", disp_x, 16'h1234);
    chk("g1_owner", disp_owner, 1'b0);
    chk("g1_valid", disp_valid, 1'b1);
    chk("g1_busy", busy, 1'b1);
    req0 = 0;
    repeat (6) tick();

    // Simultaneous requests from reset: 0 wins, 1 follows after HOLD
    clr = 1'b1; tick(); clr = 1'b0;
    req0 = 1; req1 = 1; data0 = 16'h1111; data1 = 16'h2222;
    tick();
    chk("tie_ack0", ack0, 1'b1);
    chk("tie_ack1", ack1, 1'b0);
    req0 = 0;
    wait_ack1("tie_gap", HOLD);
    chk("tie_disp", disp_x, 16'h2222);
    chk("tie_owner", disp_owner, 1'b1);
    req1 = 0;
    repeat (6) tick();

    // Owner refresh mid-hold postpones the other requester
    req0 = 1; data0 = 16'hAAAA;
    tick();
    chk("rf_ack0a", ack0, 1'b1);
    req0 = 0;
    repeat (2) tick();
    req0 = 1; data0 = 16'hBEEF; req1 = 1; data1 = 16'h3333;
    tick();
    chk("rf_ack0b", ack0, 1'b1);
    chk("rf_disp", disp_x, 16'hBEEF);
    req0 = 0;
    wait_ack1("rf_gap", HOLD);
    chk("rf_disp1", disp_x, 16'h3333);
    req1 = 0;
    repeat (6) tick();

    // Withdrawn request is never acknowledged
    req0 = 1; data0 = 16'h5555;
    tick();
    req0 = 0; req1 = 1; data1 = 16'h6666;
    tick();
    req1 = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("wd_ack1", ack1, 1'b0);
    end
    chk("wd_disp", disp_x, 16'h5555);

    // clr mid-hold, then clr during an ack cycle
    req0 = 1; data0 = 16'h7777;
    tick();
    req0 = 0;
    tick();
    clr_pulse("clr_hold");
    req1 = 1; data1 = 16'h8888;
    tick();
    req1 = 0;
    chk("clr_regrant", ack1, 1'b1);
    req0 = 1; data0 = 16'h9999;
    repeat (HOLD) tick();
    chk("clr_pre_ack", ack0, 1'b1);
    req0 = 0;
    #1 clr = 1'b1;
    #1 chk_reset_outs("clr_ack");
    @(negedge clk);
    clr = 1'b0;
    tick();

    // Timeout behaviour
    req0 = 1; data0 = 16'h00A5;
    tick();
    req0 = 0;
    repeat (HOLD + TOUT + 1) tick();
`ifdef SEG7_ARB_TIMEOUT_EN
    chk("to_disp", disp_x, 16'h0000);
    chk("to_valid", disp_valid, 1'b0);
`else
    chk("to_disp", disp_x, 16'h00A5);
    chk("to_valid", disp_valid, 1'b1);
`endif

    // Randomised protocol-abiding requesters, checked by the monitor
    pend0 = 0; pend1 = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(499) == 0) begin
        clr = 1'b1; req0 = 0; req1 = 0; pend0 = 0; pend1 = 0;
        tick();
        clr = 1'b0;
      end
      if (ack0) begin
        pend0 = ($urandom_range(3) == 0);
        req0 = pend0; data0 = 16'($urandom);
      end else if (pend0) begin
        if ($urandom_range(19) == 0) begin pend0 = 0; req0 = 0; end
      end else if ($urandom_range(5) == 0) begin
        pend0 = 1; req0 = 1; data0 = 16'($urandom);
      end
      if (ack1) begin
        pend1 = ($urandom_range(3) == 0);
        req1 = pend1; data1 = 16'($urandom);
      end else if (pend1) begin
        if ($urandom_range(19) == 0) begin pend1 = 0; req1 = 0; end
      end else if ($urandom_range(5) == 0) begin
        pend1 = 1; req1 = 1; data1 = 16'($urandom);
      end
    end
    req0 = 0; req1 = 0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
